// File: rtl/mpc_ctrl_pkg.sv
// Shared control package for the constraint-bound ROM/RAM blocks.
// Holds the default bound-word geometry and the writer FSM state encoding.
package mpc_ctrl_pkg;

  localparam int DATA_WIDTH = 20;
  localparam int ADDR_WIDTH = 3;
  localparam int ADDR_RANGE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mpc_constraint_bound_writer_if.sv
// Bundles the bound-word input stream and the RAM write port of the
// constraint-bound writer.
//
// Stream handshake: a word transfers on a rising clk edge where in_valid
// and in_ready are both high. The source may raise or drop in_valid on any
// cycle. in_ready is registered and never depends combinationally on
// in_valid.
//
// RAM port: ce0/we0/address0/d0 follow the same single-port layout the
// vsub pipeline reads with (address0/ce0/q0).
interface mpc_constraint_bound_writer_if #(
  parameter int DataWidth    = mpc_ctrl_pkg::DATA_WIDTH,
  parameter int AddressWidth = mpc_ctrl_pkg::ADDR_WIDTH
);
  logic [DataWidth-1:0]    in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [AddressWidth-1:0] address0;
  logic                    ce0;
  logic                    we0;
  logic [DataWidth-1:0]    d0;

  // Writer side: consumes the stream, drives the RAM port.
  modport slave (
    input  in_data, in_valid,
    output in_ready, address0, ce0, we0, d0
  );

  // Host side: produces the stream, observes the RAM port.
  modport master (
    output in_data, in_valid,
    input  in_ready, address0, ce0, we0, d0
  );
endinterface

// File: rtl/mpc_constraint_bound_writer.sv
// Loads one burst of AddressRange constraint-bound words from a valid/ready
// stream into a single-port RAM, in address order, one write per cycle.
// Every output is a register; the write strobe follows acceptance by one cycle.
module mpc_constraint_bound_writer
  import mpc_ctrl_pkg::*;
#(
  parameter int DataWidth    = DATA_WIDTH,
  parameter int AddressWidth = ADDR_WIDTH,
  parameter int AddressRange = ADDR_RANGE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [AddressWidth:0]   count,
  output logic [DataWidth-1:0]    checksum,
  output state_t                  dbg_state,
  mpc_constraint_bound_writer_if.slave bus
);

  localparam logic [AddressWidth:0] LastIdx = (AddressWidth + 1)'(AddressRange - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_aborted;
  logic                    r_in_ready;
  logic [AddressWidth:0]   r_count;
  logic [DataWidth-1:0]    r_checksum;
  logic [AddressWidth-1:0] r_addr;
  logic [DataWidth-1:0]    r_d;
  logic                    r_we;

  logic w_accept;
  logic w_last;
  logic w_start;
  logic w_abort_load;

  // in_ready is only ever high in LOAD, so acceptance implies LOAD.
  assign w_accept     = bus.in_valid & r_in_ready;
  assign w_last       = w_accept & (r_count == LastIdx);
  assign w_start      = (r_state == IDLE) & start & ~abort;
  assign w_abort_load = (r_state == LOAD) & abort;

  // Next-state decode; abort in LOAD wins over a simultaneous last word.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = LOAD;
      LOAD: begin
        if (abort)       w_next = IDLE;
        else if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register plus registered decodes of the upcoming state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next != IDLE);
      r_in_ready <= (w_next == LOAD);
      r_done     <= (w_next == DONE);
    end
  end

  // Burst bookkeeping: word count, XOR checksum and sticky abort flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_checksum <= '0;
      r_aborted  <= 1'b0;
    end else begin
      if (w_start) begin
        r_count    <= '0;
        r_checksum <= '0;
        r_aborted  <= 1'b0;
      end else begin
        if (w_accept) begin
          r_count    <= r_count + 1'b1;
          r_checksum <= r_checksum ^ bus.in_data;
        end
        if (w_abort_load) r_aborted <= 1'b1;
      end
    end
  end

  // RAM write strobe, one cycle after acceptance; address/data hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_d    <= '0;
    end else begin
      r_we <= w_accept;
      if (w_accept) begin
        r_addr <= r_count[AddressWidth-1:0];
        r_d    <= bus.in_data;
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign count        = r_count;
  assign checksum     = r_checksum;
  assign dbg_state    = r_state;
  assign bus.in_ready = r_in_ready;
  assign bus.ce0      = r_we;
  assign bus.we0      = r_we;
  assign bus.address0 = r_addr;
  assign bus.d0       = r_d;

endmodule

// File: doc/mpc_constraint_bound_writer.md
Name: mpc_constraint_bound_writer

Overview:
Write-side counterpart of the constraint-bound ROMs used by the dense-constraint vsub pipeline. It accepts a burst of AddressRange bound words (20-bit fixed point, alternating lower/upper) on a valid/ready stream and writes them, in address order, into a single-write-port RAM that the vsub pipeline later reads with the same address0/ce0/q0 layout. This lets the SIL host reload the constraint vector at run time instead of relying on baked-in initial contents.

Parameters:
DataWidth, 20, bit width of one bound word.
AddressWidth, 3, RAM address width.
AddressRange, 8, words per load burst (must be <= 2**AddressWidth and >= 1).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  single-cycle request to begin a load burst.
abort  in  1  cancels a burst in progress.
busy  out  1  high while in LOAD or DONE.
done  out  1  one-cycle pulse when the burst completes.
aborted  out  1  sticky flag set by abort, cleared by the next accepted start.
in_data  in  DataWidth  bound word.
in_valid  in  1  in_data is valid.
in_ready  out  1  block can accept in_data.
address0  out  AddressWidth  RAM write address.
ce0  out  1  RAM chip enable.
we0  out  1  RAM write enable.
d0  out  DataWidth  RAM write data.
count  out  AddressWidth+1  words accepted in the current or last burst.
checksum  out  DataWidth  XOR of all words written in the current or last burst.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, aborted, in_ready, ce0, we0 = 0; address0, d0, count, checksum = 0.
- Every output is registered. in_ready is a registered state decode: high exactly in LOAD.
- IDLE: start=1 and abort=0 -> LOAD; count<=0; checksum<=0; aborted<=0. start=1 with abort=1 -> stay in IDLE, no change. A start while busy is ignored.
- LOAD: a word is accepted when in_valid and in_ready are both high in the same cycle. The next cycle drives ce0=we0=1, address0=count (pre-increment value), d0=in_data. On acceptance, count<=count+1 and checksum<=checksum^in_data. Cycles with no acceptance drive ce0=we0=0, so gaps in in_valid are allowed at any point.
- Write latency: exactly 1 cycle from acceptance to the write strobe. Throughput is 1 word per cycle.
- Last word: acceptance with count==AddressRange-1 -> DONE. in_ready drops in that same next cycle, so no word beyond AddressRange is ever accepted.
- DONE, one cycle: the final write strobe is driven; done=1; then -> IDLE with busy=0. RAM contents are complete the cycle after done.
- Abort in LOAD: -> IDLE next cycle; aborted<=1; done never pulses. A write strobe already scheduled from an acceptance in the abort cycle is still issued, and count and checksum include that word. Words already written are not rolled back.
- Abort in DONE: ignored; the burst completes normally.
- Reset mid-burst: immediate return to the reset values; no further writes.
- Arithmetic: count saturates naturally at AddressRange. The checksum is a bitwise XOR with no width growth.

Decomposition:
- Shared package mpc_ctrl_pkg: state enum {IDLE, LOAD, DONE}; default DataWidth and AddressWidth constants shared with the ROM and RAM blocks.
- No sub-module is needed. Everything is a single FSM plus datapath registers. The target RAM is instantiated outside this block.

Test Plan:
- Reset, then a start pulse followed by the words A0000, 6487F, A0000, 6487F, A0000, 6487F, A0000, 6487F with in_valid held high -> writes to addresses 0..7 on 8 consecutive cycles, each 1 cycle after acceptance. done pulses alongside the address-7 write. count=8, checksum=00000.
- Same burst with in_valid low every other cycle -> identical RAM contents, no spurious we0, done 1 cycle after the final write is scheduled.
- Abort asserted in the cycle word 3 is accepted -> addresses 0..3 written, count=4, aborted=1, no done, busy=0 next cycle.
- A start pulse while in LOAD, and start and abort together in IDLE -> both ignored: no count reset, state unchanged.
- Reset deasserted then asserted mid-burst after 5 words -> all outputs at reset values immediately, no further we0; a following full burst works and aborted=0.
- A 9th word is presented with in_valid high after the 8th -> in_ready=0, the word is not accepted, and count stays 8.
